// File: rtl/pattern_scan_ctrl_if.sv
// Start/done handshake and data-memory port of the pattern-scan sequencer.
// With PATTERN_SCAN_ABORT_EN defined the bundle also carries abort/aborted.
interface pattern_scan_ctrl_if #(
  parameter int unsigned AW = 8
);
  logic          req;
  logic          busy;
  logic          done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          mem_we;
  logic [7:0]    mem_wdata;
`ifdef PATTERN_SCAN_ABORT_EN
  logic          abort;
  logic          aborted;

  modport master (
    input  req, mem_rdata, abort,
    output busy, done, mem_addr, mem_we, mem_wdata, aborted
  );
  modport slave (
    output req, mem_rdata, abort,
    input  busy, done, mem_addr, mem_we, mem_wdata, aborted
  );
`else
  modport master (
    input  req, mem_rdata,
    output busy, done, mem_addr, mem_we, mem_wdata
  );
  modport slave (
    output req, mem_rdata,
    input  busy, done, mem_addr, mem_we, mem_wdata
  );
`endif
endinterface

// File: rtl/pattern_scan_ctrl.sv
// Pattern-count sequencer: loads a 5-bit pattern, scans NBYTES message bytes and writes back
// in-byte, per-byte and cross-byte match counts. Optional abort via PATTERN_SCAN_ABORT_EN.
module pattern_scan_ctrl #(
  parameter int unsigned AW        = 8,
  parameter int unsigned BASE_ADDR = 0,
  parameter int unsigned NBYTES    = 32,
  parameter int unsigned PAT_ADDR  = 32,
  parameter int unsigned RES_ADDR  = 33
) (
  input logic                 clk,
  input logic                 reset,
  pattern_scan_ctrl_if.master bus
);

  localparam int unsigned KW = $clog2(NBYTES);

  typedef enum logic [2:0] {
    StIdle,
    StLdPat,
    StScan,
    StWrB,
    StWrO,
    StWrS,
    StDone
  } state_e;

  state_e        state_q;
  logic [KW-1:0] k_q;
  logic [4:0]    pat_q;
  logic [3:0]    tail_q;
  logic [7:0]    ctb_q, cto_q, cts_q;
  logic          busy_q, done_q, we_q;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q;
`ifdef PATTERN_SCAN_ABORT_EN
  logic          aborted_q;
`endif

  logic [7:0] b;
  logic [2:0] m, x;
  logic [7:0] ctb_n, cto_n, cts_n;
  logic       abort_now;

  // Counts 5-bit windows v[4:0], v[5:1], v[6:2], v[7:3] equal to p.
  function automatic logic [2:0] count_hits(input logic [7:0] v, input logic [4:0] p);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < 4; i++) begin
      if (v[i +: 5] == p) n = n + 3'd1;
    end
    return n;
  endfunction

  always_comb begin
    b     = bus.mem_rdata;
    m     = count_hits(b, pat_q);
    // Windows straddling the previous byte's low nibble and this byte's high nibble.
    x     = (k_q != '0) ? count_hits({tail_q, b[7:4]}, pat_q) : 3'd0;
    ctb_n = ctb_q + 8'(m);
    cto_n = cto_q + {7'd0, (m != 3'd0)};
    cts_n = cts_q + 8'(m) + 8'(x);
`ifdef PATTERN_SCAN_ABORT_EN
    abort_now = bus.abort;
`else
    abort_now = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      k_q       <= '0;
      pat_q     <= '0;
      tail_q    <= '0;
      ctb_q     <= '0;
      cto_q     <= '0;
      cts_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
`ifdef PATTERN_SCAN_ABORT_EN
      aborted_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            state_q <= StLdPat;
            busy_q  <= 1'b1;
            addr_q  <= AW'(PAT_ADDR);
          end
        end
        StLdPat, StScan: begin
          if (abort_now) begin
            state_q   <= StDone;
            done_q    <= 1'b1;
            addr_q    <= '0;
`ifdef PATTERN_SCAN_ABORT_EN
            aborted_q <= 1'b1;
`endif
          end else if (state_q == StLdPat) begin
            state_q <= StScan;
            pat_q   <= b[7:3];
            k_q     <= '0;
            tail_q  <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
            addr_q  <= AW'(BASE_ADDR);
          end else begin
            ctb_q  <= ctb_n;
            cto_q  <= cto_n;
            cts_q  <= cts_n;
            tail_q <= b[3:0];
            k_q    <= k_q + 1'b1;
            if (k_q == KW'(NBYTES - 1)) begin
              state_q <= StWrB;
              we_q    <= 1'b1;
              addr_q  <= AW'(RES_ADDR);
              wdata_q <= ctb_n;
            end else begin
              addr_q <= AW'(BASE_ADDR) + AW'(k_q) + AW'(1);
            end
          end
        end
        StWrB: begin
          state_q <= StWrO;
          addr_q  <= AW'(RES_ADDR + 1);
          wdata_q <= cto_q;
        end
        StWrO: begin
          state_q <= StWrS;
          addr_q  <= AW'(RES_ADDR + 2);
          wdata_q <= cts_q;
        end
        StWrS: begin
          state_q <= StDone;
          we_q    <= 1'b0;
          wdata_q <= '0;
          addr_q  <= '0;
          done_q  <= 1'b1;
        end
        StDone: begin
          state_q   <= StIdle;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
`ifdef PATTERN_SCAN_ABORT_EN
          aborted_q <= 1'b0;
`endif
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
`ifdef PATTERN_SCAN_ABORT_EN
  assign bus.aborted   = aborted_q;
`endif

endmodule
